// File: rtl/inv_cipher.sv
// -----------------------------------------------------------------------------
// inv_cipher: AES-128 inverse cipher (decryption core).
// It decrypts one 128-bit ciphertext block and performs one inverse round per
// clock. Round keys come from the shared expanded-key SRAM in descending order,
// rk[10] down to rk[0]. The SRAM returns a key one cycle after its address.
//
// Ports
//   clk         in   1    system clock; all state changes on the rising edge
//   reset       in   1    asynchronous, active-high; clears all state
//   en          in   1    start pulse; sampled only in IDLE
//   ciphertext  in   128  input block; latched on the edge that accepts en
//   key         in   128  round key from SRAM (rk[a] one cycle after round_no==a)
//   plaintext   out  128  working state; holds the result from en_o onward
//   round_no    out  4    SRAM round-key address, 10 down to 0
//   r_e         out  1    SRAM read enable
//   en_o        out  1    one-cycle done pulse
// -----------------------------------------------------------------------------
module inv_cipher (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic [3:0]   round_no,
  output logic         r_e,
  output logic         en_o
);

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {IDLE, INIT_SRAM, FIRST_ROUND, AES_ROUND} state_t;

  state_t       state_q;
  logic [3:0]   key_idx_q;   // index of the round key currently on 'key'
  logic [127:0] round_d;     // result of one inverse round on plaintext

  // GF(2^8) multiply by x, modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128 (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map (rotations 1, 3, 6 and constant 0x05),
  // then take the field inverse. This avoids a 256-entry table.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Byte i of the state sits at bits [127-8i -: 8]. Row r, column c is byte
  // 4c+r (column-major, MSB first). InvShiftRows rotates row r right by r, so
  // output (r,c) takes input (r, c-r mod 4).
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic         mix);
    logic [7:0]   a [4];
    logic [7:0]   m [4];
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]) ^ k[127-8*(4*c+r) -: 8];
      end
      m[0] = gmul(a[0], 8'h0e) ^ gmul(a[1], 8'h0b) ^ gmul(a[2], 8'h0d) ^ gmul(a[3], 8'h09);
      m[1] = gmul(a[0], 8'h09) ^ gmul(a[1], 8'h0e) ^ gmul(a[2], 8'h0b) ^ gmul(a[3], 8'h0d);
      m[2] = gmul(a[0], 8'h0d) ^ gmul(a[1], 8'h09) ^ gmul(a[2], 8'h0e) ^ gmul(a[3], 8'h0b);
      m[3] = gmul(a[0], 8'h0b) ^ gmul(a[1], 8'h0d) ^ gmul(a[2], 8'h09) ^ gmul(a[3], 8'h0e);
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = mix ? m[r] : a[r];
      end
    end
    return o;
  endfunction

  // The final round (rk[0]) skips InvMixColumns.
  assign round_d = inv_round(plaintext, key, key_idx_q != 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plaintext <= '0;
      round_no  <= '0;
      r_e       <= 1'b0;
      en_o      <= 1'b0;
      key_idx_q <= '0;
      state_q   <= IDLE;
    end else begin
      // The SRAM answers one cycle late, so the previous address names the key.
      key_idx_q <= round_no;
      case (state_q)
        IDLE: begin
          en_o <= 1'b0;
          r_e  <= 1'b0;
          if (en) begin
            plaintext <= ciphertext;
            round_no  <= NR;
            r_e       <= 1'b1;
            state_q   <= INIT_SRAM;
          end
        end
        INIT_SRAM: begin
          // rk[10] is in flight; issue the next address to keep the pipe full.
          round_no <= round_no - 4'd1;
          r_e      <= 1'b1;
          state_q  <= FIRST_ROUND;
        end
        FIRST_ROUND: begin
          plaintext <= plaintext ^ key;
          round_no  <= round_no - 4'd1;
          r_e       <= 1'b1;
          state_q   <= AES_ROUND;
        end
        AES_ROUND: begin
          plaintext <= round_d;
          // Saturate at 0 so the address never wraps past the key table.
          if (round_no != 4'd0) round_no <= round_no - 4'd1;
          r_e <= (round_no != 4'd0);
          if (key_idx_q == 4'd0) begin
            en_o    <= 1'b1;
            r_e     <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
